rv32_run_controller: RTL and testbench

//  Synthesisable, parametrised run controller for the rv32 core test bench.
//  - Sequences the core `enable` after a start request.
//  - Counts run cycles.
//  - Ends the run on whichever comes first: a tohost write, a PC self-loop
//    (hang), or a cycle budget (timeout). Reports pass/fail and an exit code.
//  - Sits between the bench top and the core; observes the PC and the data

---
 rtl/rv32_run_controller.sv | 204 ++++++++++++++++++++
 tb/tb_rv32_run_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_run_controller.sv
// rv32_run_controller: run controller sitting between the bench top and an rv32 core.
//   After a start request it waits START_DELAY cycles, raises the core enable and
//   counts run cycles. The run ends on the first of three events: a nonzero write to
//   TOHOST_ADDR, the pc holding one value for HANG_CYCLES enabled cycles, or the cycle
//   budget MAX_CYCLES running out. The run result is then held until restart or reset.
// Ports:
//   clock, reset_n                clock (rising edge), synchronous active-low reset
//   start                         run request, sampled only in IDLE or DONE
//   pc                            core program counter
//   mem_write_enable/address/value  core data-memory write port (observed)
//   enable, running, done         core enable, run-in-progress flag, run-finished flag
//   pass, timeout, hang           run outcome flags
//   exit_code, cycle_count        end-of-run code, RUN cycles elapsed (saturating)
// Build option: define RV32_STALL_INJECT_EN to gate enable with an LFSR during RUN,
//   producing roughly 25% stall cycles.
module rv32_run_controller #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     CYCLE_W     = 32,
  parameter int unsigned     START_DELAY = 2,
  parameter int unsigned     MAX_CYCLES  = 50,
  parameter int unsigned     HANG_CYCLES = 8,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h0000_1000)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [XLEN-1:0]    pc,
  input  logic               mem_write_enable,
  input  logic [XLEN-1:0]    mem_write_address,
  input  logic [XLEN-1:0]    mem_write_value,
  output logic               enable,
  output logic               running,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic               hang,
  output logic [XLEN-1:0]    exit_code,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam int unsigned DelayW = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);
  localparam int unsigned HangW  = $clog2(HANG_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StWait, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [DelayW-1:0]  delay_q, delay_d;
  logic [HangW-1:0]   hang_cnt_q, hang_cnt_d;
  logic [XLEN-1:0]    last_pc_q, last_pc_d;
  logic               enable_q, enable_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               timeout_q, timeout_d;
  logic               hang_q, hang_d;
  logic [XLEN-1:0]    exit_code_q, exit_code_d;
  logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;

  logic [CYCLE_W-1:0] cnt_inc;
  logic [HangW-1:0]   hang_cnt_inc;
  logic               tohost_hit, hang_hit, timeout_hit, pc_repeat, run_gate;

`ifdef RV32_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;
`endif

  always_comb begin
    state_d       = state_q;
    delay_d       = delay_q;
    hang_cnt_d    = hang_cnt_q;
    last_pc_d     = last_pc_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    hang_d        = hang_q;
    exit_code_d   = exit_code_q;
    cycle_count_d = cycle_count_q;
`ifdef RV32_STALL_INJECT_EN
    lfsr_d        = lfsr_q;
`endif

    cnt_inc     = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;
    tohost_hit  = mem_write_enable && (mem_write_address == TOHOST_ADDR) &&
                  (mem_write_value != '0);
    // A zero hang count means no enabled cycle seen yet this run: no valid last pc.
    pc_repeat    = (hang_cnt_q != '0) && (pc == last_pc_q);
    // Count of consecutive enabled cycles (including this one) with this pc value.
    hang_cnt_inc = pc_repeat ? hang_cnt_q + 1'b1 : HangW'(1);
    hang_hit     = enable_q && (hang_cnt_inc == HangW'(HANG_CYCLES));
    timeout_hit  = (cnt_inc == CYCLE_W'(MAX_CYCLES));

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          done_d        = 1'b0;
          pass_d        = 1'b0;
          timeout_d     = 1'b0;
          hang_d        = 1'b0;
          exit_code_d   = '0;
          cycle_count_d = '0;
          hang_cnt_d    = '0;
          delay_d       = '0;
`ifdef RV32_STALL_INJECT_EN
          lfsr_d        = 16'hACE1;
`endif
          if (START_DELAY == 0) begin
            state_d = StRun;
          end else begin
            state_d = StWait;
            delay_d = DelayW'(START_DELAY);
          end
        end
      end
      StWait: begin
        delay_d = delay_q - 1'b1;
        if (delay_q == DelayW'(1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        cycle_count_d = cnt_inc;
`ifdef RV32_STALL_INJECT_EN
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
        // Stalled cycles neither advance nor reset the hang tracking.
        if (enable_q) begin
          last_pc_d  = pc;
          hang_cnt_d = hang_cnt_inc;
        end
        if (tohost_hit) begin
          state_d     = StDone;
          done_d      = 1'b1;
          pass_d      = (mem_write_value == XLEN'(1));
          exit_code_d = mem_write_value >> 1;
        end else if (hang_hit) begin
          state_d     = StDone;
          done_d      = 1'b1;
          hang_d      = 1'b1;
          exit_code_d = pc;
        end else if (timeout_hit) begin
          state_d     = StDone;
          done_d      = 1'b1;
          timeout_d   = 1'b1;
          exit_code_d = '1;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef RV32_STALL_INJECT_EN
    run_gate = (lfsr_d[1:0] != 2'b00);
`else
    run_gate = 1'b1;
`endif
    running_d = (state_d == StRun);
    enable_d  = running_d && run_gate;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      delay_q       <= '0;
      hang_cnt_q    <= '0;
      last_pc_q     <= '0;
      enable_q      <= 1'b0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      hang_q        <= 1'b0;
      exit_code_q   <= '0;
      cycle_count_q <= '0;
`ifdef RV32_STALL_INJECT_EN
      lfsr_q        <= 16'hACE1;
`endif
    end else begin
      state_q       <= state_d;
      delay_q       <= delay_d;
      hang_cnt_q    <= hang_cnt_d;
      last_pc_q     <= last_pc_d;
      enable_q      <= enable_d;
      running_q     <= running_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      hang_q        <= hang_d;
      exit_code_q   <= exit_code_d;
      cycle_count_q <= cycle_count_d;
`ifdef RV32_STALL_INJECT_EN
      lfsr_q        <= lfsr_d;
`endif
    end
  end

  assign enable      = enable_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign hang        = hang_q;
  assign exit_code   = exit_code_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_rv32_run_controller.sv
// Bench for rv32_run_controller (default build, default parameters).
module tb_rv32_run_controller;

  localparam int          MAX_CYCLES  = 50;
  localparam int          HANG_CYCLES = 8;
  localparam int          NSTIM       = MAX_CYCLES + 2;
  localparam logic [31:0] TOHOST      = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset_n, start, mem_write_enable;
  logic [31:0] pc, mem_write_address, mem_write_value;
  logic        enable, running, done, pass, timeout, hang;
  logic [31:0] exit_code, cycle_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pass;
    logic        timeout;
    logic        hang;
    logic [31:0] exit_code;
    int          count;
  } result_t;

  typedef struct {
    int          wr_at;
    logic [31:0] wr_addr;
    logic [31:0] wr_val;
    int          zero_at;
    int          hang_at;
    logic        e_pass;
    logic        e_timeout;
    logic        e_hang;
    logic [31:0] e_exit;
    int          e_count;
  } vector_t;

  // Per-RUN-cycle stimulus for the current run.
  logic [31:0] pc_a   [NSTIM];
  logic        we_a   [NSTIM];
  logic [31:0] addr_a [NSTIM];
  logic [31:0] val_a  [NSTIM];
  logic        sr_a   [NSTIM];

  vector_t vecs [11];

  always #5 clock = ~clock;

  rv32_run_controller #(
    .XLEN(32), .CYCLE_W(32), .START_DELAY(2), .MAX_CYCLES(MAX_CYCLES),
    .HANG_CYCLES(HANG_CYCLES), .TOHOST_ADDR(TOHOST)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pc(pc),
    .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
    .mem_write_value(mem_write_value), .enable(enable), .running(running), .done(done),
    .pass(pass), .timeout(timeout), .hang(hang), .exit_code(exit_code),
    .cycle_count(cycle_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Outcome of a run from the stimulus arrays: scan RUN cycles in order, tracking how
  // long the pc has held its value; the first cycle with any end event decides.
  function automatic result_t model();
    result_t r;
    int      held;
    held = 0;
    r = '{pass: 1'b0, timeout: 1'b0, hang: 1'b0, exit_code: 32'h0, count: 0};
    for (int i = 0; i < MAX_CYCLES; i++) begin
      held = (i > 0 && pc_a[i] == pc_a[i-1]) ? held + 1 : 1;
      if (we_a[i] && addr_a[i] == TOHOST && val_a[i] != 0) begin
        r.pass = (val_a[i] == 1); r.exit_code = val_a[i] / 2; r.count = i + 1;
        return r;
      end
      if (held >= HANG_CYCLES) begin
        r.hang = 1'b1; r.exit_code = pc_a[i]; r.count = i + 1;
        return r;
      end
      if (i == MAX_CYCLES - 1) begin
        r.timeout = 1'b1; r.exit_code = 32'hFFFF_FFFF; r.count = i + 1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic load_vector(input vector_t v);
    for (int i = 0; i < NSTIM; i++) begin
      pc_a[i]   = (v.hang_at >= 0 && i >= v.hang_at) ? 32'h80 : 32'h100 + 32'(4 * i);
      we_a[i]   = (i == v.wr_at) || (i == v.zero_at);
      addr_a[i] = (i == v.wr_at) ? v.wr_addr : TOHOST;
      val_a[i]  = (i == v.wr_at) ? v.wr_val : 32'h0;
      sr_a[i]   = 1'b0;
    end
  endtask

  task automatic load_random();
    int rep;
    rep = ($urandom_range(2) == 0) ? 50 : (($urandom_range(1) == 0) ? 85 : 95);
    for (int i = 0; i < NSTIM; i++) begin
      if (i > 0 && $urandom_range(99) < rep) pc_a[i] = pc_a[i-1];
      else pc_a[i] = 32'h80 + 32'(4 * $urandom_range(15));
      we_a[i]   = ($urandom_range(19) == 0);
      addr_a[i] = ($urandom_range(3) == 0) ? TOHOST + 32'h4 : TOHOST;
      val_a[i]  = ($urandom_range(3) == 0) ? $urandom() : 32'($urandom_range(3));
      sr_a[i]   = ($urandom_range(7) == 0);
    end
  endtask

  // Start a run (from IDLE or DONE), drive the stimulus arrays and check against exp.
  task automatic exec_run(input string tag, input result_t exp);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, " start_clr"}, {enable, running, done, pass, timeout, hang, exit_code,
        cycle_count}, 64'h0);
    @(posedge clock); #1;
    chk({tag, " wait"}, {enable, running}, 2'b00);
    @(posedge clock); #1;
    chk({tag, " run_entry"}, {enable, running, done, cycle_count}, {3'b110, 32'h0});
    for (int i = 0; i < NSTIM; i++) begin
      @(negedge clock);
      pc                = pc_a[i];
      mem_write_enable  = we_a[i];
      mem_write_address = addr_a[i];
      mem_write_value   = val_a[i];
      start             = sr_a[i];
      @(posedge clock); #1;
      start            = 1'b0;
      mem_write_enable = 1'b0;
      if (i == exp.count - 1) begin
        chk({tag, " end_flags"}, {enable, running, done, pass, timeout, hang},
            {3'b001, exp.pass, exp.timeout, exp.hang});
        chk({tag, " exit_code"}, exit_code, exp.exit_code);
        chk({tag, " cycle_count"}, cycle_count, 32'(exp.count));
        break;
      end
      chk({tag, " in_run"}, {running, enable, done, cycle_count}, {3'b110, 32'(i + 1)});
    end
    // DONE must hold its result against further activity.
    @(negedge clock);
    pc = 32'h80; mem_write_enable = 1'b1; mem_write_address = TOHOST; mem_write_value = 1;
    @(posedge clock); #1;
    mem_write_enable = 1'b0;
    chk({tag, " frozen"}, {enable, running, done, pass, timeout, hang, exit_code,
        cycle_count}, {3'b001, exp.pass, exp.timeout, exp.hang, exp.exit_code,
        32'(exp.count)});
  endtask

  function automatic result_t vec_result(input vector_t v);
    result_t r;
    r = '{pass: v.e_pass, timeout: v.e_timeout, hang: v.e_hang, exit_code: v.e_exit,
          count: v.e_count};
    return r;
  endfunction

  initial begin
    //          wr_at wr_addr        wr_val        zero hang  pass to hg exit           cnt
    vecs[0]  = '{10, TOHOST,         32'h1,        -1, -1,   1, 0, 0, 32'h0,         11};
    vecs[1]  = '{5,  TOHOST,         32'h7,         3, -1,   0, 0, 0, 32'h3,          6};
    vecs[2]  = '{-1, TOHOST,         32'h0,        -1, -1,   0, 1, 0, 32'hFFFF_FFFF, 50};
    vecs[3]  = '{49, TOHOST,         32'h1,        -1, -1,   1, 0, 0, 32'h0,         50};
    vecs[4]  = '{-1, TOHOST,         32'h0,        -1,  4,   0, 0, 1, 32'h80,        12};
    vecs[5]  = '{-1, TOHOST,         32'h0,        -1,  0,   0, 0, 1, 32'h80,         8};
    vecs[6]  = '{7,  TOHOST,         32'h5,        -1,  0,   0, 0, 0, 32'h2,          8};
    vecs[7]  = '{-1, TOHOST,         32'h0,        -1, 42,   0, 0, 1, 32'h80,        50};
    vecs[8]  = '{5,  TOHOST + 32'h4, 32'h1,        -1, -1,   0, 1, 0, 32'hFFFF_FFFF, 50};
    vecs[9]  = '{0,  TOHOST,         32'h1,        -1, -1,   1, 0, 0, 32'h0,          1};
    vecs[10] = '{20, TOHOST,         32'h8000_0001, -1, -1,  0, 0, 0, 32'h4000_0000, 21};

    reset_n = 1'b0; start = 1'b0; pc = 32'h0;
    mem_write_enable = 1'b0; mem_write_address = 32'h0; mem_write_value = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", {enable, running, done, pass, timeout, hang, exit_code, cycle_count},
        64'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      load_vector(vecs[v]);
      exec_run($sformatf("vec%0d", v), vec_result(vecs[v]));
    end

    // Reset in the middle of a run aborts it; a new start begins again from zero.
    @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (7) begin
      @(negedge clock);
      pc = pc + 32'h4;
    end
    #1;
    chk("midrun_running", {running, enable}, 2'b11);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("midrun_reset", {enable, running, done, pass, timeout, hang, exit_code,
        cycle_count}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    load_vector(vecs[0]);
    exec_run("rerun", vec_result(vecs[0]));

    for (int r = 0; r < 25; r++) begin
      load_random();
      exec_run($sformatf("rand%0d", r), model());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
